regfile_wb_scheduler: RTL

//   Sequences access to the 32x32 register file write port and guards its read ports. Arbitrates write-back

---
 rtl/regfile_wb_scheduler.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler
//   Owns the register-file write port. Each cycle it picks one write-back source: the ALU pipe,
//   which cannot be back-pressured and always wins, or the head of a small FIFO that buffers
//   long-latency (load/mul/div) results. The winner is registered onto rf_we/rf_addr/rf_data.
//   It also keeps a scoreboard of outstanding long-latency destinations and stalls decode on
//   RAW/WAW hazards or when too many long operations are in flight.
//
// Ports
//   clock, reset_n                     clock, asynchronous active-low reset
//   issue_valid/rs/rt/dst/dst_we/long  decode-stage instruction
//   issue_stall                        combinational decode hold
//   alu_wb_valid/addr/data             ALU write-back request
//   lu_wb_valid/ready/addr/data        long-unit write-back, valid/ready handshake into FIFO
//   rf_we/rf_addr/rf_data              registered register-file write port
//   wb_stall_req                       asks the pipeline to withhold ALU write-backs
//   pending                            scoreboard, one bit per architectural register
//   err_sticky                         protocol violation seen since reset
module regfile_wb_scheduler #(
  parameter int unsigned LU_FIFO_DEPTH   = 2,
  parameter int unsigned STARVE_LIMIT    = 4,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rs,
  input  logic [4:0]  issue_rt,
  input  logic [4:0]  issue_dst,
  input  logic        issue_dst_we,
  input  logic        issue_long,
  output logic        issue_stall,
  input  logic        alu_wb_valid,
  input  logic [4:0]  alu_wb_addr,
  input  logic [31:0] alu_wb_data,
  input  logic        lu_wb_valid,
  output logic        lu_wb_ready,
  input  logic [4:0]  lu_wb_addr,
  input  logic [31:0] lu_wb_data,
  output logic        rf_we,
  output logic [4:0]  rf_addr,
  output logic [31:0] rf_data,
  output logic        wb_stall_req,
  output logic [31:0] pending,
  output logic        err_sticky
);

  localparam int unsigned PtrW    = (LU_FIFO_DEPTH > 1) ? $clog2(LU_FIFO_DEPTH) : 1;
  localparam int unsigned CntW    = PtrW + 1;
  localparam int unsigned StarveW = $clog2(STARVE_LIMIT) + 1;
  localparam int unsigned OutW    = $clog2(MAX_OUTSTANDING + 1);

  logic [31:0]        pending_q, pending_d;
  logic [OutW-1:0]    outstanding_q, outstanding_d;
  logic [CntW-1:0]    count_q, count_d;
  logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [StarveW-1:0] starve_q, starve_d;
  logic               rf_we_q, rf_we_d;
  logic               rf_from_lu_q, rf_from_lu_d;
  logic [4:0]         rf_addr_q, rf_addr_d;
  logic [31:0]        rf_data_q, rf_data_d;
  logic               wb_stall_req_q, wb_stall_req_d;
  logic               err_q, err_d;

  logic [4:0]  fifo_addr [LU_FIFO_DEPTH];
  logic [31:0] fifo_data [LU_FIFO_DEPTH];

  logic fifo_empty, fifo_full, push, pop, issue_fire, lu_set, lu_retire;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CntW'(LU_FIFO_DEPTH));
  // Readiness comes from the registered count only: a full FIFO refuses pushes even while popping.
  assign push       = lu_wb_valid & ~fifo_full;
  assign pop        = ~alu_wb_valid & ~fifo_empty;

  assign issue_stall = issue_valid & (pending_q[issue_rs] | pending_q[issue_rt]
                     | (issue_dst_we & pending_q[issue_dst])
                     | (issue_long & issue_dst_we & (outstanding_q == OutW'(MAX_OUTSTANDING))));
  assign issue_fire  = issue_valid & ~issue_stall;
  assign lu_set      = issue_fire & issue_dst_we & issue_long & (issue_dst != 5'd0);
  // A long result retires on the edge that ends its rf write cycle.
  assign lu_retire   = rf_we_q & rf_from_lu_q;

  always_comb begin
    pending_d     = pending_q;
    outstanding_d = outstanding_q;
    // Guarded so a stray FIFO entry for a non-pending register cannot corrupt the count.
    if (lu_retire && pending_q[rf_addr_q]) begin
      pending_d[rf_addr_q] = 1'b0;
      outstanding_d        = outstanding_d - OutW'(1);
    end
    if (lu_set) begin
      pending_d[issue_dst] = 1'b1;
      outstanding_d        = outstanding_d + OutW'(1);
    end
    pending_d[0] = 1'b0;
  end

  always_comb begin
    rf_we_d      = 1'b0;
    rf_from_lu_d = 1'b0;
    rf_addr_d    = rf_addr_q;
    rf_data_d    = rf_data_q;
    if (alu_wb_valid) begin
      rf_we_d   = (alu_wb_addr != 5'd0);
      rf_addr_d = alu_wb_addr;
      rf_data_d = alu_wb_data;
    end else if (pop) begin
      // Entries for r0 are still consumed, they just never reach the register file.
      rf_we_d      = (fifo_addr[rd_ptr_q] != 5'd0);
      rf_from_lu_d = 1'b1;
      rf_addr_d    = fifo_addr[rd_ptr_q];
      rf_data_d    = fifo_data[rd_ptr_q];
    end
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    starve_d       = starve_q;
    wb_stall_req_d = wb_stall_req_q;
    if (pop) begin
      starve_d       = '0;
      wb_stall_req_d = 1'b0;
    end else if (!fifo_empty && alu_wb_valid) begin
      if (starve_q != StarveW'(STARVE_LIMIT - 1)) begin
        starve_d = starve_q + StarveW'(1);
      end else begin
        wb_stall_req_d = 1'b1;
      end
    end
  end

  assign err_d = err_q | (alu_wb_valid & wb_stall_req_q) | (lu_wb_valid & ~pending_q[lu_wb_addr]);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending_q      <= '0;
      outstanding_q  <= '0;
      count_q        <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      starve_q       <= '0;
      rf_we_q        <= 1'b0;
      rf_from_lu_q   <= 1'b0;
      rf_addr_q      <= '0;
      rf_data_q      <= '0;
      wb_stall_req_q <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      pending_q      <= pending_d;
      outstanding_q  <= outstanding_d;
      count_q        <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      starve_q       <= starve_d;
      rf_we_q        <= rf_we_d;
      rf_from_lu_q   <= rf_from_lu_d;
      rf_addr_q      <= rf_addr_d;
      rf_data_q      <= rf_data_d;
      wb_stall_req_q <= wb_stall_req_d;
      err_q          <= err_d;
    end
  end

  // Storage needs no reset: the pointers and count define which entries are live.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_addr[wr_ptr_q] <= lu_wb_addr;
      fifo_data[wr_ptr_q] <= lu_wb_data;
    end
  end

  assign lu_wb_ready  = ~fifo_full;
  assign rf_we        = rf_we_q;
  assign rf_addr      = rf_addr_q;
  assign rf_data      = rf_data_q;
  assign wb_stall_req = wb_stall_req_q;
  assign pending      = pending_q;
  assign err_sticky   = err_q;

endmodule
